hps_design_clkgen_div: RTL and testbench

Parametrised multi-channel clock-enable generator running entirely in the `refclk` domain; successor to the fixed two-output PLL wrapper in `hps_design`. It produces `NUM_CLOCKS` divided clock waveforms and matching one-cycle enables, each with its own runtime-programmable integer divide ratio and phase offset. All channels are re-aligned together on every reconfiguration, and a `locked` flag is asserted after a settle interval. Fabric logic uses it to derive slow, phase-related strobes without another PLL.

---
 rtl/hps_design_clkgen_div.sv | 98 +++++++++
 tb/tb_hps_design_clkgen_div.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hps_design_clkgen_div.sv
// hps_design_clkgen_div: multi-channel divided clock/enable generator, all channels realigned on every reconfiguration
module hps_design_clkgen_div #(
    parameter int NUM_CLOCKS  = 4,
    parameter int DIV_WIDTH   = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_channel,
    input  logic [DIV_WIDTH-1:0]  cfg_divide,
    input  logic [DIV_WIDTH-1:0]  cfg_phase,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_en,
    output logic                  locked
);
    localparam int LW  = $clog2(LOCK_CYCLES + 1);
    localparam int DEF = (DEFAULT_DIV < 1) ? 1 : DEFAULT_DIV;
    typedef enum logic [1:0] {RESET, SETTLE, LOCKED, APPLY} state_t;
    state_t state_q, state_d;
    logic [LW-1:0] settle_q, settle_d;
    logic acc, ch_ok, start, active;
    logic [DIV_WIDTH-1:0] div_new, ph_new;
    assign cfg_ready = (state_q == SETTLE) || (state_q == LOCKED);
    assign locked    = state_q == LOCKED;
    assign acc       = cfg_valid && cfg_ready;
    assign ch_ok     = {1'b0, cfg_channel} < (CH_W+1)'(NUM_CLOCKS);
    assign start     = (state_d == SETTLE) && (state_q == RESET || state_q == APPLY);
    assign active    = (state_d == SETTLE) || (state_d == LOCKED);
    assign div_new   = (cfg_divide == '0) ? DIV_WIDTH'(1) : cfg_divide;
    assign ph_new    = (cfg_phase >= div_new) ? div_new - DIV_WIDTH'(1) : cfg_phase;
    always_comb begin
        state_d  = state_q;
        settle_d = (state_q == SETTLE) ? settle_q + LW'(1) : '0;
        if (rst)
            state_d = RESET;
        else if (state_q == RESET || state_q == APPLY)
            state_d = SETTLE;
        else if (acc && ch_ok)
            state_d = APPLY;
        else if (state_q == SETTLE && settle_q == LW'(LOCK_CYCLES - 1))
            state_d = LOCKED;
    end
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= RESET;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end
    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
        logic [DIV_WIDTH-1:0] div_q, ph_q, cnt_q, cnt_d;
        logic [DIV_WIDTH:0] half;
        logic run_q, run_d, clk_q, en_q, wr;
        assign wr   = acc && ch_ok && (cfg_channel == CH_W'(i));
        assign half = ({1'b0, div_q} + (DIV_WIDTH+1)'(1)) >> 1;
        // cnt counts down the phase delay until run, then counts 0..D-1
        always_comb begin
            run_d = run_q;
            cnt_d = cnt_q;
            if (start) begin
                run_d = ph_q == '0;
                cnt_d = ph_q;
            end else if (!run_q) begin
                run_d = cnt_q == DIV_WIDTH'(1);
                cnt_d = cnt_q - DIV_WIDTH'(1);
            end else begin
                cnt_d = (cnt_q == div_q - DIV_WIDTH'(1)) ? '0 : cnt_q + DIV_WIDTH'(1);
            end
        end
        always_ff @(posedge refclk) begin
            if (rst) begin
                div_q <= DIV_WIDTH'(DEF);
                ph_q  <= '0;
                cnt_q <= '0;
                run_q <= 1'b0;
                clk_q <= 1'b0;
                en_q  <= 1'b0;
            end else begin
                if (wr) begin
                    div_q <= div_new;
                    ph_q  <= ph_new;
                end
                cnt_q <= cnt_d;
                run_q <= run_d;
                clk_q <= active && run_d && ({1'b0, cnt_d} < half);
                en_q  <= active && run_d && (cnt_d == '0);
            end
        end
        assign outclk[i]    = clk_q;
        assign outclk_en[i] = en_q;
    end
endmodule

// File: tb/tb_hps_design_clkgen_div.sv
// tb_hps_design_clkgen_div: directed vectors with a cycle-stamped expectation queue checked by an independent monitor
module tb_hps_design_clkgen_div;
    logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_ready, locked;
    logic [1:0] cfg_channel = '0;
    logic [7:0] cfg_divide = '0, cfg_phase = '0;
    logic [2:0] outclk, outclk_en;
    int cyc = 0, n_cmp = 0, n_bad = 0;
    typedef struct packed { int c; logic [2:0] o, e, m; logic l, r; } exp_t;
    exp_t sb[$];
    string nq[$];
    exp_t me;
    string mn;
    localparam logic [2:0] O2 [10] = '{3'd5, 3'd0, 3'd7, 3'd2, 3'd7, 3'd0, 3'd5, 3'd2, 3'd7, 3'd2};
    localparam logic [2:0] E2 [10] = '{3'd5, 3'd0, 3'd7, 3'd0, 3'd5, 3'd0, 3'd5, 3'd2, 3'd5, 3'd0};
    localparam logic [2:0] O3 [6]  = '{3'd4, 3'd4, 3'd5, 3'd5, 3'd4, 3'd5};
    localparam logic [2:0] E3 [6]  = '{3'd4, 3'd4, 3'd5, 3'd4, 3'd4, 3'd5};
    localparam logic [2:0] O5 [6]  = '{3'd0, 3'd2, 3'd2, 3'd0, 3'd2, 3'd2};
    localparam logic [2:0] E5 [6]  = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd2, 3'd0};
    localparam logic [7:0] DV [6]  = '{8'd4, 8'd7, 8'd6, 8'd9, 8'd3, 8'd8};
    localparam logic [7:0] PV [6]  = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};

    hps_design_clkgen_div #(.NUM_CLOCKS(3), .DIV_WIDTH(8), .LOCK_CYCLES(16), .DEFAULT_DIV(2)) dut (
        .refclk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_channel(cfg_channel), .cfg_divide(cfg_divide), .cfg_phase(cfg_phase),
        .outclk(outclk), .outclk_en(outclk_en), .locked(locked));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            me = sb.pop_front();
            mn = nq.pop_front();
            n_cmp++;
            if (me.c != cyc || (outclk & me.m) !== (me.o & me.m) || (outclk_en & me.m) !== (me.e & me.m)
                || locked !== me.l || cfg_ready !== me.r) begin
                n_bad++;
                $display("FAIL %s cyc=%0d want_cyc=%0d mask=%b outclk=%b want=%b en=%b want=%b locked=%b want=%b ready=%b want=%b",
                         mn, cyc, me.c, me.m, outclk, me.o, outclk_en, me.e, locked, me.l, cfg_ready, me.r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int cc);
        while (cyc < cc) tick();
    endtask

    task automatic ex(input int cc, input logic [2:0] o, e, m, input logic l, r, input string nm);
        sb.push_back('{c: cc, o: o, e: e, m: m, l: l, r: r});
        nq.push_back(nm);
    endtask

    task automatic req(input logic [1:0] ch, input logic [7:0] d, p);
        cfg_valid = 1'b1;
        cfg_channel = ch;
        cfg_divide = d;
        cfg_phase = p;
    endtask

    initial begin
        int s, a, a2, s2, c, b, s3, s4;
        repeat (3) tick();
        ex(cyc, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, "reset");
        rst = 1'b0;
        s = cyc + 1;
        for (int j = 0; j < 6; j++)
            ex(s + j, (j % 2 != 0) ? 3'd0 : 3'd7, (j % 2 != 0) ? 3'd0 : 3'd7, 3'd7, 1'b0, 1'b1, "default_wave");
        ex(s + 15, 3'd0, 3'd0, 3'd7, 1'b0, 1'b1, "pre_lock");
        ex(s + 16, 3'd7, 3'd7, 3'd7, 1'b1, 1'b1, "lock");
        wait_to(s + 17);
        a = cyc;
        req(2'd1, 8'd5, 8'd2);
        ex(a, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, "ch1_accept");
        ex(a + 1, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, "ch1_apply");
        s = a + 2;
        for (int j = 0; j < 10; j++) ex(s + j, O2[j], E2[j], 3'd7, 1'b0, 1'b1, "ch1_d5p2");
        ex(s + 12, 3'd7, 3'd7, 3'd7, 1'b0, 1'b1, "ch1_en3");
        ex(s + 15, 3'd0, 3'd0, 3'd7, 1'b0, 1'b1, "ch1_prelock");
        ex(s + 16, 3'd5, 3'd5, 3'd7, 1'b1, 1'b1, "ch1_lock");
        tick();
        cfg_valid = 1'b0;
        wait_to(s + 17);
        a = cyc;
        req(2'd2, 8'd0, 8'd0);
        ex(a, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, "d0_accept");
        ex(a + 1, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, "d0_apply");
        s = a + 2;
        for (int j = 0; j < 5; j++) ex(s + j, 3'd4, 3'd4, 3'd4, 1'b0, 1'b1, "d0_const");
        tick();
        cfg_valid = 1'b0;
        wait_to(s + 5);
        a2 = cyc;
        req(2'd0, 8'd3, 8'd7);
        ex(a2, 3'd4, 3'd4, 3'd4, 1'b0, 1'b1, "settle_req");
        ex(a2 + 1, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, "settle_apply");
        s2 = a2 + 2;
        for (int j = 0; j < 6; j++) ex(s2 + j, O3[j], E3[j], 3'd5, 1'b0, 1'b1, "p_clamp");
        ex(s2 + 14, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, "settle_restart");
        ex(s2 + 16, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, "clamp_lock");
        tick();
        cfg_valid = 1'b0;
        wait_to(s2 + 17);
        c = cyc;
        req(2'd3, 8'd9, 8'd0);
        ex(c, 3'd7, 3'd7, 3'd7, 1'b1, 1'b1, "bad_ch_0");
        ex(c + 1, 3'd7, 3'd4, 3'd7, 1'b1, 1'b1, "bad_ch_1");
        ex(c + 2, 3'd6, 3'd4, 3'd7, 1'b1, 1'b1, "bad_ch_2");
        ex(c + 3, 3'd5, 3'd5, 3'd7, 1'b1, 1'b1, "bad_ch_3");
        tick();
        cfg_valid = 1'b0;
        wait_to(c + 4);
        b = cyc;
        for (int k = 0; k < 6; k++)
            ex(b + k, 3'd0, 3'd0, (k % 2 != 0) ? 3'd7 : 3'd0, (k == 0) ? 1'b1 : 1'b0, (k % 2 == 0), "held_valid");
        s3 = b + 6;
        for (int j = 0; j < 6; j++) ex(s3 + j, O5[j], E5[j], 3'd2, 1'b0, 1'b1, "third_xfer");
        for (int k = 0; k < 6; k++) begin
            req(2'd1, DV[k], PV[k]);
            tick();
        end
        cfg_valid = 1'b0;
        wait_to(s3 + 8);
        rst = 1'b1;
        ex(s3 + 9, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0, "mid_reset");
        tick();
        rst = 1'b0;
        s4 = cyc + 1;
        for (int j = 0; j < 4; j++)
            ex(s4 + j, (j % 2 != 0) ? 3'd0 : 3'd7, (j % 2 != 0) ? 3'd0 : 3'd7, 3'd7, 1'b0, 1'b1, "reset_default");
        ex(s4 + 15, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, "reset_prelock");
        ex(s4 + 16, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, "reset_lock");
        wait_to(s4 + 17);
        for (int k = 0; k < 40 && sb.size() > 0; k++) tick();
        if (sb.size() > 0) begin
            n_bad += sb.size();
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
